// File: rtl/uvmt_cv32e40x_sl_obi_responder.sv
// OBI responder model (memory side): grants requests, queues them and returns in-order
// read responses after a configurable latency, with address-decoded errors and a sticky protocol check.
module uvmt_cv32e40x_sl_obi_responder #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter logic [31:0] RDATA_XOR       = 32'hA5A5_A5A5,
  parameter logic [31:0] ERR_ADDR_BASE   = 32'hFFFF_FFFF,
  parameter logic [31:0] ERR_ADDR_MASK   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        gnt_stall_i,
  input  logic        resp_stall_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [3:0]  outstanding_o,
  output logic        protocol_err_o
);

  localparam int unsigned    PW      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned    DEPTH   = 1 << PW;
  localparam logic [PW-1:0]  LAST    = PW'(MAX_OUTSTANDING - 1);
  localparam logic [3:0]     LAT     = 4'(RESP_LATENCY);
  localparam logic [3:0]     MAX_OUT = 4'(MAX_OUTSTANDING);

  logic [31:0]   slot_addr_q [DEPTH];
  logic          slot_err_q  [DEPTH];
  logic [3:0]    slot_age_q  [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]    q_cnt_q, q_cnt_d;
  logic [3:0]    outstanding_q, outstanding_d;
  logic          rvalid_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          resp_err_q, resp_err_d;
  logic          perr_q, perr_d;
  logic          pend_q, pend_d;
  logic [31:0]   pend_addr_q;

  logic          accept, req_err, head_from_q, head_vld, head_err, issue, bypass, push, pop;
  logic [31:0]   head_addr;
  logic [3:0]    head_age;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Handshake: an address phase transfers in any cycle where req_i && gnt_o; once req_i is
  // raised without gnt_o, req_i and addr_i must stay stable until the grant cycle.
  always_comb begin
    gnt_o   = !rst_i && req_i && !gnt_stall_i && (outstanding_q < MAX_OUT);
    accept  = req_i && gnt_o;
    req_err = ((addr_i & ERR_ADDR_MASK) == ERR_ADDR_BASE);
  end

  // An empty queue lets a request accepted this cycle answer at this edge when latency is 1.
  always_comb begin
    head_from_q = (q_cnt_q != 4'd0);
    head_vld    = 1'b0;
    head_addr   = addr_i;
    head_err    = req_err;
    head_age    = 4'd0;
    if (head_from_q) begin
      head_vld  = 1'b1;
      head_addr = slot_addr_q[rd_ptr_q];
      head_err  = slot_err_q[rd_ptr_q];
      head_age  = slot_age_q[rd_ptr_q];
    end else begin
      head_vld  = accept;
    end
    issue  = head_vld && !resp_stall_i && (({1'b0, head_age} + 5'd1) >= {1'b0, LAT});
    bypass = issue && !head_from_q;
    push   = accept && !bypass;
    pop    = issue && head_from_q;
  end

  always_comb begin
    wr_ptr_d      = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d      = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    q_cnt_d       = q_cnt_q + {3'b000, push} - {3'b000, pop};
    // A slot stays occupied through the cycle its response is visible on rvalid_o.
    outstanding_d = outstanding_q + {3'b000, accept} - {3'b000, rvalid_q};
    rdata_d       = rdata_q;
    resp_err_d    = resp_err_q;
    if (issue) begin
      rdata_d    = head_err ? 32'h0 : (head_addr ^ RDATA_XOR);
      resp_err_d = head_err;
    end
    perr_d = perr_q || (pend_q && (!req_i || (addr_i != pend_addr_q)));
    pend_d = req_i && !gnt_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_addr_q[PW'(i)] <= 32'h0;
        slot_err_q[PW'(i)]  <= 1'b0;
        slot_age_q[PW'(i)]  <= 4'd0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      q_cnt_q       <= 4'd0;
      outstanding_q <= 4'd0;
      rvalid_q      <= 1'b0;
      rdata_q       <= 32'h0;
      resp_err_q    <= 1'b0;
      perr_q        <= 1'b0;
      pend_q        <= 1'b0;
      pend_addr_q   <= 32'h0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_age_q[PW'(i)] <= (slot_age_q[PW'(i)] >= LAT) ? LAT : slot_age_q[PW'(i)] + 4'd1;
      end
      if (push) begin
        slot_addr_q[wr_ptr_q] <= addr_i;
        slot_err_q[wr_ptr_q]  <= req_err;
        slot_age_q[wr_ptr_q]  <= 4'd1;
      end
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      q_cnt_q       <= q_cnt_d;
      outstanding_q <= outstanding_d;
      rvalid_q      <= issue;
      rdata_q       <= rdata_d;
      resp_err_q    <= resp_err_d;
      perr_q        <= perr_d;
      pend_q        <= pend_d;
      pend_addr_q   <= addr_i;
    end
  end

  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;
  assign err_o          = resp_err_q;
  assign outstanding_o  = outstanding_q;
  assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_uvmt_cv32e40x_sl_obi_responder.sv
// Bench for the OBI responder: a latency-1 instance with an error region driven from a vector
// table, and a latency-3 instance exercised by hand sequences plus a scoreboarded random run.
module tb_uvmt_cv32e40x_sl_obi_responder;

  localparam logic [31:0] XOR = 32'hA5A5_A5A5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: latency 1, depth 2, error region 0x1xxx_xxxx
  logic        rst_a, req_a, gs_a, rs_a;
  logic [31:0] addr_a;
  logic        gnt_a, rvalid_a, err_a, perr_a;
  logic [31:0] rdata_a;
  logic [3:0]  outs_a;

  // instance B: latency 3, depth 2, no error region
  logic        rst_b, req_b, gs_b, rs_b;
  logic [31:0] addr_b;
  logic        gnt_b, rvalid_b, err_b, perr_b;
  logic [31:0] rdata_b;
  logic [3:0]  outs_b;

  uvmt_cv32e40x_sl_obi_responder #(
    .MAX_OUTSTANDING(2), .RESP_LATENCY(1), .RDATA_XOR(XOR),
    .ERR_ADDR_BASE(32'h1000_0000), .ERR_ADDR_MASK(32'hF000_0000)
  ) dut_a (
    .clk_i(clk), .rst_i(rst_a), .req_i(req_a), .addr_i(addr_a),
    .gnt_stall_i(gs_a), .resp_stall_i(rs_a), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
    .rdata_o(rdata_a), .err_o(err_a), .outstanding_o(outs_a), .protocol_err_o(perr_a)
  );

  uvmt_cv32e40x_sl_obi_responder #(
    .MAX_OUTSTANDING(2), .RESP_LATENCY(3), .RDATA_XOR(XOR)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .addr_i(addr_b),
    .gnt_stall_i(gs_b), .resp_stall_i(rs_b), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
    .rdata_o(rdata_b), .err_o(err_b), .outstanding_o(outs_b), .protocol_err_o(perr_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- vector table for instance A ----------------
  typedef struct {
    logic        rst, req, gs, rs;
    logic [31:0] addr;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  outs;
    logic        perr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic req, input logic gs, input logic rs,
                     input logic [31:0] addr, input logic gnt, input logic rv,
                     input logic [31:0] rdata, input logic err, input logic [3:0] outs,
                     input logic perr);
    vec_t v;
    v = '{rst: rst, req: req, gs: gs, rs: rs, addr: addr, gnt: gnt, rv: rv,
          rdata: rdata, err: err, outs: outs, perr: perr};
    vq.push_back(v);
  endtask

  // ---------------- scoreboard for instance B ----------------
  logic [31:0] exp_q[$];
  int          model_out = 0;
  logic        mon_on = 1'b0;
  logic        exp_g;

  always @(negedge clk) begin
    if (mon_on) begin
      if (rst_b) begin
        model_out = 0;
        exp_q.delete();
      end else begin
        exp_g = req_b && !gs_b && (model_out < 2);
        check("b_gnt_model", {31'b0, gnt_b}, {31'b0, exp_g});
        check("b_outstanding_model", {28'b0, outs_b}, 32'(model_out));
        if (rvalid_b) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL b_resp_order: response %h arrived with nothing pending", rdata_b);
          end else begin
            check("b_resp_rdata", rdata_b, exp_q.pop_front());
            check("b_resp_err", {31'b0, err_b}, 32'd0);
          end
        end
        if (req_b && exp_g) exp_q.push_back(addr_b ^ XOR);
        model_out = model_out + ((req_b && exp_g) ? 1 : 0) - (rvalid_b ? 1 : 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Enters and leaves one cycle at posedge+1; checks land at posedge+2.
  task automatic cyc_b(input logic req, input logic [31:0] addr, input logic e_gnt,
                       input logic e_rv, input logic [31:0] e_rdata, input logic [3:0] e_outs,
                       input int c);
    req_b = req; addr_b = addr;
    #1;
    check($sformatf("b_hand_c%0d_gnt", c), {31'b0, gnt_b}, {31'b0, e_gnt});
    check($sformatf("b_hand_c%0d_rvalid", c), {31'b0, rvalid_b}, {31'b0, e_rv});
    check($sformatf("b_hand_c%0d_outstanding", c), {28'b0, outs_b}, {28'b0, e_outs});
    if (e_rv) check($sformatf("b_hand_c%0d_rdata", c), rdata_b, e_rdata);
    @(posedge clk); #1;
  endtask

  logic last_g;

  initial begin
    rst_a = 1'b1; req_a = 1'b0; gs_a = 1'b0; rs_a = 1'b0; addr_a = 32'h0;
    rst_b = 1'b1; req_b = 1'b0; gs_b = 1'b0; rs_b = 1'b0; addr_b = 32'h0;
    mon_on = 1'b1;

    //   rst req gs rs addr           gnt rv rdata          err out perr
    add(0, 1, 0, 0, 32'h0000_0100, 1, 0, 32'h0000_0000, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,         0, 1, 32'hA5A5_A4A5, 0, 1, 0);
    add(0, 0, 0, 0, 32'h0,         0, 0, 32'hA5A5_A4A5, 0, 0, 0);
    add(0, 1, 0, 0, 32'h0000_0000, 1, 0, 32'hA5A5_A4A5, 0, 0, 0);
    add(0, 1, 0, 0, 32'h0000_0004, 1, 1, 32'hA5A5_A5A5, 0, 1, 0);
    add(0, 1, 0, 0, 32'h0000_0008, 1, 1, 32'hA5A5_A5A1, 0, 1, 0);
    add(0, 0, 0, 0, 32'h0,         0, 1, 32'hA5A5_A5AD, 0, 1, 0);
    add(0, 0, 0, 0, 32'h0,         0, 0, 32'hA5A5_A5AD, 0, 0, 0);
    add(0, 1, 0, 0, 32'h1000_0040, 1, 0, 32'hA5A5_A5AD, 0, 0, 0);
    add(0, 1, 0, 0, 32'h2000_0000, 1, 1, 32'h0000_0000, 1, 1, 0);
    add(0, 0, 0, 0, 32'h0,         0, 1, 32'h85A5_A5A5, 0, 1, 0);
    add(0, 0, 0, 0, 32'h0,         0, 0, 32'h85A5_A5A5, 0, 0, 0);
    add(0, 1, 0, 1, 32'h0000_0200, 1, 0, 32'h85A5_A5A5, 0, 0, 0);
    add(0, 1, 0, 1, 32'h0000_0204, 1, 0, 32'h85A5_A5A5, 0, 1, 0);
    add(0, 0, 0, 1, 32'h0,         0, 0, 32'h85A5_A5A5, 0, 2, 0);
    add(0, 0, 0, 1, 32'h0,         0, 0, 32'h85A5_A5A5, 0, 2, 0);
    add(0, 0, 0, 1, 32'h0,         0, 0, 32'h85A5_A5A5, 0, 2, 0);
    add(0, 0, 0, 0, 32'h0,         0, 0, 32'h85A5_A5A5, 0, 2, 0);
    add(0, 0, 0, 0, 32'h0,         0, 1, 32'hA5A5_A7A5, 0, 2, 0);
    add(0, 0, 0, 0, 32'h0,         0, 1, 32'hA5A5_A7A1, 0, 1, 0);
    add(0, 0, 0, 0, 32'h0,         0, 0, 32'hA5A5_A7A1, 0, 0, 0);
    add(0, 1, 1, 0, 32'h0000_0040, 0, 0, 32'hA5A5_A7A1, 0, 0, 0);
    add(0, 1, 1, 0, 32'h0000_0044, 0, 0, 32'hA5A5_A7A1, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,         0, 0, 32'hA5A5_A7A1, 0, 0, 1);
    add(0, 0, 0, 0, 32'h0,         0, 0, 32'hA5A5_A7A1, 0, 0, 1);
    add(0, 1, 0, 1, 32'h0000_0500, 1, 0, 32'hA5A5_A7A1, 0, 0, 1);
    add(0, 1, 0, 1, 32'h0000_0504, 1, 0, 32'hA5A5_A7A1, 0, 1, 1);
    add(1, 0, 0, 0, 32'h0,         0, 0, 32'hA5A5_A7A1, 0, 2, 1);
    add(0, 0, 0, 0, 32'h0,         0, 0, 32'h0000_0000, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,         0, 0, 32'h0000_0000, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,         0, 0, 32'h0000_0000, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b0;

    // ---------------- table-driven phase on A ----------------
    for (int i = 0; i < vq.size(); i++) begin
      rst_a = vq[i].rst; req_a = vq[i].req; gs_a = vq[i].gs; rs_a = vq[i].rs;
      addr_a = vq[i].addr;
      #1;
      check($sformatf("a_c%0d_gnt", i), {31'b0, gnt_a}, {31'b0, vq[i].gnt});
      check($sformatf("a_c%0d_rvalid", i), {31'b0, rvalid_a}, {31'b0, vq[i].rv});
      check($sformatf("a_c%0d_rdata", i), rdata_a, vq[i].rdata);
      check($sformatf("a_c%0d_err", i), {31'b0, err_a}, {31'b0, vq[i].err});
      check($sformatf("a_c%0d_outstanding", i), {28'b0, outs_a}, {28'b0, vq[i].outs});
      check($sformatf("a_c%0d_protocol_err", i), {31'b0, perr_a}, {31'b0, vq[i].perr});
      @(posedge clk); #1;
    end

    // ---------------- hand sequence on B: latency 3, fill to full ----------------
    cyc_b(1, 32'h10, 1, 0, 32'h0,          4'd0, 0);
    cyc_b(1, 32'h14, 1, 0, 32'h0,          4'd1, 1);
    cyc_b(1, 32'h18, 0, 0, 32'h0,          4'd2, 2);
    cyc_b(1, 32'h18, 0, 1, 32'hA5A5_A5B5, 4'd2, 3);
    cyc_b(1, 32'h18, 1, 1, 32'hA5A5_A5B1, 4'd1, 4);
    cyc_b(0, 32'h0,  0, 0, 32'h0,          4'd1, 5);
    cyc_b(0, 32'h0,  0, 0, 32'h0,          4'd1, 6);
    cyc_b(0, 32'h0,  0, 1, 32'hA5A5_A5BD, 4'd1, 7);
    cyc_b(0, 32'h0,  0, 0, 32'h0,          4'd0, 8);

    // ---------------- random phase on B, scoreboard checks ordering ----------------
    last_g = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (!(req_b && !last_g)) begin
        req_b  = 1'($urandom_range(0, 1));
        addr_b = 32'($urandom_range(0, 1023)) << 2;
      end
      gs_b = ($urandom_range(0, 3) == 0);
      rs_b = ($urandom_range(0, 3) == 0);
      #1;
      last_g = gnt_b;
    end
    for (int i = 0; i < 20 && req_b && !last_g; i++) begin
      @(posedge clk); #1;
      gs_b = 1'b0; rs_b = 1'b0;
      #1;
      last_g = gnt_b;
    end
    @(posedge clk); #1;
    req_b = 1'b0; gs_b = 1'b0; rs_b = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    check("b_drain_pending", 32'(exp_q.size()), 32'd0);
    check("b_drain_outstanding", {28'b0, outs_b}, 32'd0);
    check("b_protocol_err_clean", {31'b0, perr_b}, 32'd0);

    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
